mc_ctrl: RTL and testbench

Multi-cycle control sequencer for the MIPS datapath. It replaces single-cycle decode with an FSM that steps each instruction through fetch, decode, execute, memory and writeback. It drives the datapath select encodings (RegDst, ALUSrc, MemtoReg, ExtOp, ALUOp, nPCOp) and gates all architectural write enables (PC, IR, GPR, data memory) per state. It also stalls on instruction-memory and data-memory ready handshakes and counts retired instructions.

---
 rtl/mc_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control sequencer.
// Steps each instruction through FETCH/DCD/EXE/MEM/WB/WBM/JMP, drives the
// datapath select encodings, gates architectural write enables per state,
// stalls on memory ready handshakes and counts retired instructions.
module mc_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Op,
    input  logic [5:0]       Func,
    input  logic             Zero,
    input  logic             IReady,
    input  logic             DReady,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       RegDst,
    output logic             ALUSrc,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       ExtOp,
    output logic [3:0]       ALUOp,
    output logic [2:0]       nPCOp,
    output logic             Retire,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstrCnt
);

    // opcode / function encodings
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // datapath select encodings
    localparam logic [1:0] DST_RT    = 2'b00;
    localparam logic [1:0] DST_RD    = 2'b01;
    localparam logic [1:0] DST_RA    = 2'b10;
    localparam logic [1:0] M2R_ALU   = 2'b00;
    localparam logic [1:0] M2R_MEM   = 2'b01;
    localparam logic [1:0] M2R_PC4   = 2'b10;
    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_LUI   = 2'b10;
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_OR    = 4'b0010;
    localparam logic [2:0] NPC_SEQ   = 3'b000;
    localparam logic [2:0] NPC_BR    = 3'b001;
    localparam logic [2:0] NPC_JUMP  = 3'b010;
    localparam logic [2:0] NPC_JR    = 3'b011;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DCD   = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_WBM   = 3'd5,
        S_JMP   = 3'd6
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;

    logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, is_jal;

    logic       exe_alu_src;
    logic [1:0] exe_ext_op;
    logic [3:0] exe_alu_op;

    logic       pc_wr, ir_wr, reg_write, mem_read, mem_write;
    logic [1:0] reg_dst, mem_to_reg, ext_op;
    logic       alu_src;
    logic [3:0] alu_op;
    logic [2:0] npc_op;
    logic       retire, illegal;

    // instruction decode from the IR fields
    always_comb begin
        is_r    = (Op == OP_RTYPE);
        is_addu = is_r && (Func == FN_ADDU);
        is_subu = is_r && (Func == FN_SUBU);
        is_jr   = is_r && (Func == FN_JR);
        is_ori  = (Op == OP_ORI);
        is_lui  = (Op == OP_LUI);
        is_lw   = (Op == OP_LW);
        is_sw   = (Op == OP_SW);
        is_beq  = (Op == OP_BEQ);
        is_j    = (Op == OP_J);
        is_jal  = (Op == OP_JAL);
    end

    // ALU-side selects chosen in EXE and held through MEM/WB/WBM
    always_comb begin
        exe_alu_src = 1'b0;
        exe_ext_op  = EXT_SIGN;
        exe_alu_op  = ALU_ADD;
        if (is_subu || is_beq) begin
            exe_alu_op = ALU_SUB;
        end
        if (is_ori) begin
            exe_alu_src = 1'b1;
            exe_ext_op  = EXT_ZERO;
            exe_alu_op  = ALU_OR;
        end
        if (is_lui) begin
            exe_alu_src = 1'b1;
            exe_ext_op  = EXT_LUI;
        end
        if (is_lw || is_sw) begin
            exe_alu_src = 1'b1;
        end
    end

    // next-state and per-state control outputs
    always_comb begin
        state_nxt  = state;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_dst    = DST_RT;
        alu_src    = 1'b0;
        mem_to_reg = M2R_ALU;
        ext_op     = EXT_SIGN;
        alu_op     = ALU_ADD;
        npc_op     = NPC_SEQ;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                pc_wr = IReady;
                ir_wr = IReady;
                if (IReady) begin
                    state_nxt = S_DCD;
                end
            end
            S_DCD: begin
                if (is_j || is_jal || is_jr) begin
                    state_nxt = S_JMP;
                end else if (is_addu || is_subu || is_ori || is_lui ||
                             is_lw || is_sw || is_beq) begin
                    state_nxt = S_EXE;
                end else begin
                    illegal   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_EXE: begin
                alu_src = exe_alu_src;
                ext_op  = exe_ext_op;
                alu_op  = exe_alu_op;
                if (is_beq) begin
                    npc_op    = NPC_BR;
                    pc_wr     = Zero;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_nxt = S_MEM;
                end else if (is_addu || is_subu || is_ori || is_lui) begin
                    state_nxt = S_WB;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_MEM: begin
                alu_src   = exe_alu_src;
                ext_op    = exe_ext_op;
                alu_op    = exe_alu_op;
                mem_read  = is_lw;
                mem_write = is_sw;
                if (DReady) begin
                    if (is_lw) begin
                        state_nxt = S_WBM;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_WB: begin
                alu_src   = exe_alu_src;
                ext_op    = exe_ext_op;
                alu_op    = exe_alu_op;
                reg_write = 1'b1;
                reg_dst   = is_r ? DST_RD : DST_RT;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_WBM: begin
                alu_src    = exe_alu_src;
                ext_op     = exe_ext_op;
                alu_op     = exe_alu_op;
                reg_write  = 1'b1;
                mem_to_reg = M2R_MEM;
                retire     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_JMP: begin
                pc_wr  = 1'b1;
                npc_op = is_jr ? NPC_JR : NPC_JUMP;
                if (is_jal) begin
                    reg_write  = 1'b1;
                    reg_dst    = DST_RA;
                    mem_to_reg = M2R_PC4;
                end
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (retire) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // outputs are forced quiet while reset is held
    assign PCWr     = rst_n & pc_wr;
    assign IRWr     = rst_n & ir_wr;
    assign RegWrite = rst_n & reg_write;
    assign MemRead  = rst_n & mem_read;
    assign MemWrite = rst_n & mem_write;
    assign Retire   = rst_n & retire;
    assign Illegal  = rst_n & illegal;
    assign RegDst   = rst_n ? reg_dst    : 2'b00;
    assign ALUSrc   = rst_n & alu_src;
    assign MemtoReg = rst_n ? mem_to_reg : 2'b00;
    assign ExtOp    = rst_n ? ext_op     : 2'b00;
    assign ALUOp    = rst_n ? alu_op     : 4'b0000;
    assign nPCOp    = rst_n ? npc_op     : 3'b000;
    assign InstrCnt = cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl. Stimulus pushes the expected
// control word and counts for every cycle; a negedge monitor pops and compares.
// A second instance with a 4-bit counter shares the inputs to exercise wrap.
module tb_mc_ctrl;

    typedef struct packed {
        logic       pcwr;
        logic       irwr;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic [1:0] regdst;
        logic       alusrc;
        logic [1:0] memtoreg;
        logic [1:0] extop;
        logic [3:0] aluop;
        logic [2:0] npcop;
        logic       retire;
        logic       illegal;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  op, func;
    logic        zero, iready, dready;

    logic        pcwr, irwr, regwrite, memread, memwrite, alusrc, retire, illegal;
    logic [1:0]  regdst, memtoreg, extop;
    logic [3:0]  aluop;
    logic [2:0]  npcop;
    logic [31:0] instrcnt;

    logic        b_pcwr, b_irwr, b_regwrite, b_memread, b_memwrite, b_alusrc, b_retire, b_illegal;
    logic [1:0]  b_regdst, b_memtoreg, b_extop;
    logic [3:0]  b_aluop;
    logic [2:0]  b_npcop;
    logic [3:0]  b_instrcnt;

    mc_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .Op(op), .Func(func), .Zero(zero),
        .IReady(iready), .DReady(dready),
        .PCWr(pcwr), .IRWr(irwr), .RegWrite(regwrite), .MemRead(memread),
        .MemWrite(memwrite), .RegDst(regdst), .ALUSrc(alusrc),
        .MemtoReg(memtoreg), .ExtOp(extop), .ALUOp(aluop), .nPCOp(npcop),
        .Retire(retire), .Illegal(illegal), .InstrCnt(instrcnt)
    );

    mc_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .Op(op), .Func(func), .Zero(zero),
        .IReady(iready), .DReady(dready),
        .PCWr(b_pcwr), .IRWr(b_irwr), .RegWrite(b_regwrite), .MemRead(b_memread),
        .MemWrite(b_memwrite), .RegDst(b_regdst), .ALUSrc(b_alusrc),
        .MemtoReg(b_memtoreg), .ExtOp(b_extop), .ALUOp(b_aluop), .nPCOp(b_npcop),
        .Retire(b_retire), .Illegal(b_illegal), .InstrCnt(b_instrcnt)
    );

    always #5 clk = ~clk;

    ctl_t        q_ctl[$];
    logic [31:0] q_cnt[$];
    int          total = 0;
    int          bad = 0;
    int          ncyc = 0;
    int unsigned ecnt = 0;

    ctl_t        exp_v, act_v;
    logic [31:0] exp_c;
    logic [3:0]  exp_c4;

    function automatic ctl_t mk(input logic pw, iw, rw, mr, mw,
                                input logic [1:0] rd, input logic as,
                                input logic [1:0] mt, ex, input logic [3:0] al,
                                input logic [2:0] np, input logic rt, il);
        mk = {pw, iw, rw, mr, mw, rd, as, mt, ex, al, np, rt, il};
    endfunction

    // one clock of stimulus with its expected control word
    task automatic cyc(input logic ir, dr, z, input ctl_t v);
        iready = ir;
        dready = dr;
        zero   = z;
        q_ctl.push_back(v);
        q_cnt.push_back(32'(ecnt));
        @(posedge clk);
        #1;
        if (v.retire) ecnt++;
    endtask

    // monitor: compare DUT outputs against the queued expectation
    always @(negedge clk) begin
        if (q_ctl.size() != 0) begin
            exp_v  = q_ctl.pop_front();
            exp_c  = q_cnt.pop_front();
            exp_c4 = exp_c[3:0];
            act_v  = {pcwr, irwr, regwrite, memread, memwrite, regdst, alusrc,
                      memtoreg, extop, aluop, npcop, retire, illegal};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL ctl cyc=%0d got=%06h want=%06h", ncyc, act_v, exp_v);
            end
            total++;
            if (instrcnt !== exp_c) begin
                bad++;
                $display("FAIL cnt32 cyc=%0d got=%0d want=%0d", ncyc, instrcnt, exp_c);
            end
            total++;
            if (b_instrcnt !== exp_c4) begin
                bad++;
                $display("FAIL cnt4 cyc=%0d got=%0d want=%0d", ncyc, b_instrcnt, exp_c4);
            end
            ncyc++;
        end
    end

    ctl_t vf, v0;

    initial begin
        vf = mk(1,1,0,0,0, 2'b00,0,2'b00,2'b00,4'h0,3'b000,0,0);
        v0 = '0;
        rst_n = 1'b0; op = 6'h00; func = 6'h00;
        zero = 1'b0; iready = 1'b1; dready = 1'b1;
        @(posedge clk);
        #1;
        // reset held: everything quiet even with IReady high
        cyc(1,1,0,v0);
        cyc(1,1,0,v0);
        rst_n = 1'b1;

        // addu
        op = 6'h00; func = 6'h21;
        cyc(1,1,0,vf);
        cyc(1,1,0,v0);
        cyc(1,1,0,v0);
        cyc(1,1,0,mk(0,0,1,0,0, 2'b01,0,2'b00,2'b00,4'h0,3'b000,1,0));

        // lw with DReady low for three MEM cycles
        op = 6'h23;
        cyc(1,1,0,vf);
        cyc(1,1,0,v0);
        cyc(1,1,0,mk(0,0,0,0,0, 2'b00,1,2'b00,2'b00,4'h0,3'b000,0,0));
        repeat (3) cyc(1,0,0,mk(0,0,0,1,0, 2'b00,1,2'b00,2'b00,4'h0,3'b000,0,0));
        cyc(1,1,0,mk(0,0,0,1,0, 2'b00,1,2'b00,2'b00,4'h0,3'b000,0,0));
        cyc(1,1,0,mk(0,0,1,0,0, 2'b00,1,2'b01,2'b00,4'h0,3'b000,1,0));

        // beq taken, then not taken
        op = 6'h04;
        cyc(1,1,0,vf);
        cyc(1,1,0,v0);
        cyc(1,1,1,mk(1,0,0,0,0, 2'b00,0,2'b00,2'b00,4'h1,3'b001,1,0));
        cyc(1,1,0,vf);
        cyc(1,1,0,v0);
        cyc(1,1,0,mk(0,0,0,0,0, 2'b00,0,2'b00,2'b00,4'h1,3'b001,1,0));

        // jal
        op = 6'h03;
        cyc(1,1,0,vf);
        cyc(1,1,0,v0);
        cyc(1,1,0,mk(1,0,1,0,0, 2'b10,0,2'b10,2'b00,4'h0,3'b010,1,0));

        // jr
        op = 6'h00; func = 6'h08;
        cyc(1,1,0,vf);
        cyc(1,1,0,v0);
        cyc(1,1,0,mk(1,0,0,0,0, 2'b00,0,2'b00,2'b00,4'h0,3'b011,1,0));

        // illegal opcode 3Fh
        op = 6'h3F;
        cyc(1,1,0,vf);
        cyc(1,1,0,mk(0,0,0,0,0, 2'b00,0,2'b00,2'b00,4'h0,3'b000,0,1));

        // IReady low in FETCH: no writes, hold
        op = 6'h00; func = 6'h20;
        repeat (5) cyc(0,1,0,v0);

        // illegal R-type function 20h
        cyc(1,1,0,vf);
        cyc(1,1,0,mk(0,0,0,0,0, 2'b00,0,2'b00,2'b00,4'h0,3'b000,0,1));

        // subu
        func = 6'h23;
        cyc(1,1,0,vf);
        cyc(1,1,0,v0);
        cyc(1,1,0,mk(0,0,0,0,0, 2'b00,0,2'b00,2'b00,4'h1,3'b000,0,0));
        cyc(1,1,0,mk(0,0,1,0,0, 2'b01,0,2'b00,2'b00,4'h1,3'b000,1,0));

        // ori
        op = 6'h0D;
        cyc(1,1,0,vf);
        cyc(1,1,0,v0);
        cyc(1,1,0,mk(0,0,0,0,0, 2'b00,1,2'b00,2'b01,4'h2,3'b000,0,0));
        cyc(1,1,0,mk(0,0,1,0,0, 2'b00,1,2'b00,2'b01,4'h2,3'b000,1,0));

        // lui
        op = 6'h0F;
        cyc(1,1,0,vf);
        cyc(1,1,0,v0);
        cyc(1,1,0,mk(0,0,0,0,0, 2'b00,1,2'b00,2'b10,4'h0,3'b000,0,0));
        cyc(1,1,0,mk(0,0,1,0,0, 2'b00,1,2'b00,2'b10,4'h0,3'b000,1,0));

        // j
        op = 6'h02;
        cyc(1,1,0,vf);
        cyc(1,1,0,v0);
        cyc(1,1,0,mk(1,0,0,0,0, 2'b00,0,2'b00,2'b00,4'h0,3'b010,1,0));

        // sw, DReady high
        op = 6'h2B;
        cyc(1,1,0,vf);
        cyc(1,1,0,v0);
        cyc(1,1,0,mk(0,0,0,0,0, 2'b00,1,2'b00,2'b00,4'h0,3'b000,0,0));
        cyc(1,1,0,mk(0,0,0,0,1, 2'b00,1,2'b00,2'b00,4'h0,3'b000,1,0));

        // sw stalled in MEM, then reset mid-instruction
        cyc(1,1,0,vf);
        cyc(1,1,0,v0);
        cyc(1,1,0,mk(0,0,0,0,0, 2'b00,1,2'b00,2'b00,4'h0,3'b000,0,0));
        cyc(1,0,0,mk(0,0,0,0,1, 2'b00,1,2'b00,2'b00,4'h0,3'b000,0,0));
        rst_n = 1'b0;
        ecnt  = 0;
        cyc(1,0,0,v0);
        cyc(1,1,0,v0);
        rst_n = 1'b1;
        // back in FETCH with no leftover memory write
        cyc(0,1,0,v0);

        // 16 jumps: 32-bit count reaches 16, 4-bit count wraps to 0
        op = 6'h02;
        for (int i = 0; i < 16; i++) begin
            cyc(1,1,0,vf);
            cyc(1,1,0,v0);
            cyc(1,1,0,mk(1,0,0,0,0, 2'b00,0,2'b00,2'b00,4'h0,3'b010,1,0));
        end
        cyc(0,1,0,v0);

        // drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 10 && q_ctl.size() != 0; k++) @(posedge clk);
        if (q_ctl.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", q_ctl.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
